// File: rtl/sine_pwm_pkg.sv
// Shared constants, state encoding and sample-to-duty conversion for the
// sine-driven PWM modulator.
package sine_pwm_pkg;

  localparam int SAMPLE_W = 9;
  localparam int PHASE_W  = 8;
  localparam int CNT_W    = 9;
  localparam int DUTY_W   = 10;
  localparam int DT_W     = 4;

  localparam logic [CNT_W-1:0]  CARRIER_MAX = 9'd509;
  localparam logic [DUTY_W-1:0] DUTY_OFFSET = 10'd255;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DT   = 2'b01,
    HI   = 2'b10,
    LO   = 2'b11
  } dt_state_e;

  // Only -256 lands below zero (as 10'h3FF); every other sample maps into 0..510.
  function automatic logic [DUTY_W-1:0] sample_to_duty(input logic [SAMPLE_W-1:0] sample);
    logic [DUTY_W-1:0] sum;
    sum = {sample[SAMPLE_W-1], sample} + DUTY_OFFSET;
    return sum[DUTY_W-1] ? '0 : sum;
  endfunction

endpackage

// File: rtl/sine_pwm_mod_dead_time_gen.sv
// Dead-time generator: turns the raw PWM level into complementary high/low
// gate drives separated by at least DEAD low-low clocks.
module dead_time_gen
  import sine_pwm_pkg::*;
#(
  parameter int DEAD = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic raw_q,
  output logic pwm_h,
  output logic pwm_l
);

  localparam logic [DT_W-1:0] DT_LOAD = DT_W'(DEAD - 1);

  dt_state_e       state_reg, state_next;
  logic [DT_W-1:0] dt_cnt_reg, dt_cnt_next;
  logic            dt_first_reg, dt_first_next;
  logic            raw_d_reg;
  logic            pwm_h_reg, pwm_l_reg;

  always_comb begin
    state_next    = state_reg;
    dt_cnt_next   = dt_cnt_reg;
    dt_first_next = 1'b0;
    if (!en) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          state_next    = DT;
          dt_cnt_next   = DT_LOAD;
          dt_first_next = 1'b1;
        end
        DT: begin
          // The entry cycle is skipped: the level that caused entry is not a new change.
          if (!dt_first_reg && (raw_q != raw_d_reg)) begin
            dt_cnt_next = DT_LOAD;
          end else if (dt_cnt_reg == '0) begin
            state_next = raw_q ? HI : LO;
          end else begin
            dt_cnt_next = dt_cnt_reg - 1'b1;
          end
        end
        HI: begin
          if (!raw_q) begin
            state_next    = DT;
            dt_cnt_next   = DT_LOAD;
            dt_first_next = 1'b1;
          end
        end
        LO: begin
          if (raw_q) begin
            state_next    = DT;
            dt_cnt_next   = DT_LOAD;
            dt_first_next = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Drives are flopped from the next state so they equal a decode of the
  // state register while staying glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      dt_cnt_reg   <= '0;
      dt_first_reg <= 1'b0;
      raw_d_reg    <= 1'b0;
      pwm_h_reg    <= 1'b0;
      pwm_l_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      dt_cnt_reg   <= dt_cnt_next;
      dt_first_reg <= dt_first_next;
      raw_d_reg    <= raw_q;
      pwm_h_reg    <= (state_next == HI);
      pwm_l_reg    <= (state_next == LO);
    end
  end

  assign pwm_h = pwm_h_reg;
  assign pwm_l = pwm_l_reg;

endmodule

// File: rtl/sine_pwm_mod.sv
// Sine PWM modulator: 510-cycle carrier, duty taken from the sine LUT once per
// period, phase advanced by PHASE_STEP, complementary outputs with dead time.
module sine_pwm_mod
  import sine_pwm_pkg::*;
#(
  parameter int                 DEAD       = 4,
  parameter logic [PHASE_W-1:0] PHASE_STEP = 8'd1
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                EN,
  input  logic [SAMPLE_W-1:0] SINE_IN,
  output logic [PHASE_W-1:0]  THETA_OUT,
  output logic                PWM_H,
  output logic                PWM_L,
  output logic                PERIOD_STRB
);

  logic [CNT_W-1:0]   cnt_reg;
  logic [DUTY_W-1:0]  duty_r_reg;
  logic [DUTY_W-1:0]  duty_next;
  logic               raw_q_reg;
  logic [PHASE_W-1:0] theta_reg;
  logic               strb_reg;

  assign duty_next = sample_to_duty(SINE_IN);

  // Duty and phase change only at the period boundary, so the LUT sample
  // is consumed once per period and never mid-period.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_reg    <= '0;
      duty_r_reg <= DUTY_OFFSET;
      raw_q_reg  <= 1'b0;
      theta_reg  <= '0;
      strb_reg   <= 1'b0;
    end else begin
      strb_reg <= 1'b0;
      if (!EN) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CARRIER_MAX) begin
        cnt_reg    <= '0;
        duty_r_reg <= duty_next;
        theta_reg  <= theta_reg + PHASE_STEP;
        strb_reg   <= 1'b1;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
      raw_q_reg <= EN && ({1'b0, cnt_reg} < duty_r_reg);
    end
  end

  dead_time_gen #(
    .DEAD (DEAD)
  ) u_dead_time (
    .clk   (CLK),
    .rst_n (RST_N),
    .en    (EN),
    .raw_q (raw_q_reg),
    .pwm_h (PWM_H),
    .pwm_l (PWM_L)
  );

  assign THETA_OUT   = theta_reg;
  assign PERIOD_STRB = strb_reg;

endmodule

// File: tb/tb_sine_pwm_mod.sv
// Directed bench for sine_pwm_mod: per-period high/low counts checked against
// a scoreboard of expected windows, plus reset, enable and phase checks.
module tb_sine_pwm_mod;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       EN;
  logic [8:0] SINE_IN;
  logic [7:0] theta, theta64;
  logic       pwm_h, pwm_l, strb;
  logic       pwm_h64, pwm_l64, strb64;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string tag;
    int    h;
    int    l;
    int    k;
  } exp_t;

  exp_t sb[$];

  always #5 CLK = ~CLK;

  sine_pwm_mod #(.DEAD(4), .PHASE_STEP(8'd1)) u_dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .EN          (EN),
    .SINE_IN     (SINE_IN),
    .THETA_OUT   (theta),
    .PWM_H       (pwm_h),
    .PWM_L       (pwm_l),
    .PERIOD_STRB (strb)
  );

  sine_pwm_mod #(.DEAD(4), .PHASE_STEP(8'd64)) u_dut64 (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .EN          (EN),
    .SINE_IN     (SINE_IN),
    .THETA_OUT   (theta64),
    .PWM_H       (pwm_h64),
    .PWM_L       (pwm_l64),
    .PERIOD_STRB (strb64)
  );

  task automatic chk(input string tag, input integer obs, input integer exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Gate drives must never overlap.
  always @(negedge CLK) begin
    if (RST_N === 1'b1) begin
      checks++;
      assert (!(pwm_h === 1'b1 && pwm_l === 1'b1)) else begin
        errors++;
        $error("FAIL overlap: observed pwm_h=%b pwm_l=%b expected not both 1", pwm_h, pwm_l);
      end
    end
  end

  function automatic void sb_push(input string tag, input int h, input int l, input int k);
    exp_t e;
    e.tag = tag;
    e.h   = h;
    e.l   = l;
    e.k   = k;
    sb.push_back(e);
  endfunction

  task automatic wait_strobe(output int n);
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (strb !== 1'b1 && n < 2000);
  endtask

  // Starts on a strobe cycle, counts one full window, ends on the next strobe.
  task automatic measure();
    exp_t       e;
    int         h = 0;
    int         l = 0;
    int         len = 0;
    logic [7:0] t1, t64;
    if (sb.size() == 0) begin
      chk("sb_underflow", sb.size(), 1);
      return;
    end
    e   = sb.pop_front();
    t1  = theta;
    t64 = theta64;
    do begin
      if (pwm_h === 1'b1) h++;
      if (pwm_l === 1'b1) l++;
      len++;
      @(negedge CLK);
    end while (strb !== 1'b1 && len < 2000);
    $display("window %s k=%0d h=%0d l=%0d len=%0d theta=%0d theta64=%0d",
             e.tag, e.k, h, l, len, t1, t64);
    chk({e.tag, "_h"}, h, e.h);
    chk({e.tag, "_l"}, l, e.l);
    chk({e.tag, "_len"}, len, 510);
    chk({e.tag, "_theta"}, t1, e.k % 256);
    chk({e.tag, "_theta64"}, t64, (e.k * 64) % 256);
  endtask

  // Counts low-low cycles from enable/reset release until PWM_H first rises.
  task automatic dt_before_drive(input string tag, output int used);
    int low = 0;
    int lseen = 0;
    used = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      used++;
      if (pwm_h === 1'b1) break;
      if (pwm_l === 1'b1) lseen++;
      else low++;
    end
    $display("startup %s low_cycles=%0d", tag, low);
    chk({tag, "_dt"}, low, 4);
    chk({tag, "_l"}, lseen, 0);
  endtask

  initial begin
    int         used, n, strobes, hl;
    logic [7:0] th_hold;

    RST_N   = 1'b0;
    EN      = 1'b0;
    SINE_IN = 9'd0;
    repeat (3) @(negedge CLK);
    chk("rst_h", pwm_h, 0);
    chk("rst_l", pwm_l, 0);
    chk("rst_strb", strb, 0);
    chk("rst_theta", theta, 0);
    chk("rst_theta64", theta64, 0);

    EN    = 1'b1;
    RST_N = 1'b1;
    dt_before_drive("start", used);
    wait_strobe(n);
    chk("start_strobe", used + n, 510);

    sb_push("half1", 251, 251, 1);
    measure();

    SINE_IN = 9'd255;
    sb_push("half2", 251, 251, 2);
    sb_push("full_in", 504, 2, 3);
    measure();
    measure();

    SINE_IN = 9'h100;
    sb_push("full", 510, 0, 4);
    sb_push("clamp_in", 2, 504, 5);
    measure();
    measure();

    SINE_IN = 9'h103;
    sb_push("clamp", 0, 510, 6);
    sb_push("short_in", 0, 504, 7);
    sb_push("short", 0, 504, 8);
    measure();
    measure();
    measure();

    SINE_IN = 9'd0;
    sb_push("short_out", 0, 504, 9);
    sb_push("half3", 251, 251, 10);
    measure();
    measure();

    // Enable drop at cnt = 100 while the high side is driving.
    repeat (100) @(negedge CLK);
    chk("pre_dis_h", pwm_h, 1);
    chk("pre_dis_l", pwm_l, 0);
    EN = 1'b0;
    @(negedge CLK);
    chk("dis_h", pwm_h, 0);
    chk("dis_l", pwm_l, 0);
    th_hold = theta;
    strobes = 0;
    hl      = 0;
    repeat (600) begin
      @(negedge CLK);
      if (strb === 1'b1) strobes++;
      if (pwm_h === 1'b1 || pwm_l === 1'b1) hl++;
    end
    $display("disabled strobes=%0d drive_cycles=%0d theta=%0d", strobes, hl, theta);
    chk("dis_strobes", strobes, 0);
    chk("dis_drive", hl, 0);
    chk("dis_theta_frozen", theta, th_hold);
    chk("dis_theta", theta, 11);
    chk("dis_theta64", theta64, 192);

    EN = 1'b1;
    dt_before_drive("reen", used);
    wait_strobe(n);
    chk("reen_strobe", used + n, 510);
    chk("reen_theta", theta, 12);
    chk("reen_theta64", theta64, 0);

    // Asynchronous reset in the middle of a high-side pulse.
    repeat (100) @(negedge CLK);
    chk("pre_rst_h", pwm_h, 1);
    #2 RST_N = 1'b0;
    #1;
    $display("async reset h=%b l=%b strb=%b theta=%0d", pwm_h, pwm_l, strb, theta);
    chk("arst_h", pwm_h, 0);
    chk("arst_l", pwm_l, 0);
    chk("arst_strb", strb, 0);
    chk("arst_theta", theta, 0);
    chk("arst_theta64", theta64, 0);
    repeat (3) @(negedge CLK);
    RST_N = 1'b1;
    dt_before_drive("rst_rel", used);
    wait_strobe(n);
    chk("rst_rel_strobe", used + n, 510);
    chk("rst_rel_theta", theta, 1);
    chk("rst_rel_theta64", theta64, 64);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sine_pwm_mod.md
Name: sine_pwm_mod

Overview:
- Consumer end of the sine lookup interface: drives the 8-bit phase into the sine LUT and takes back its 9-bit two's-complement sample.
- Converts each sample into a centre-offset duty cycle on a free-running 510-cycle carrier.
- Produces complementary high/low-side gate drives with programmable dead time for the DE0_NANO PWM output stage.
- Advances the phase once per carrier period, so the output synthesises a sine.

Parameters:
- DEAD, 4, dead-time length in clocks; legal range 1..15.
- PHASE_STEP, 1, phase increment per carrier period; 8-bit; wraps modulo 256.

Ports:
- CLK  in  1  system clock
- RST_N  in  1  reset, asynchronous, active-low
- EN  in  1  modulator enable
- SINE_IN  in  9  two's-complement sample from the sine LUT, valid for the current THETA_OUT
- THETA_OUT  out  8  phase driven to the sine LUT
- PWM_H  out  1  high-side gate drive
- PWM_L  out  1  low-side gate drive
- PERIOD_STRB  out  1  one-cycle pulse marking the first cycle of each carrier period

Behaviour:
- Reset: RST_N low forces these values immediately, regardless of CLK:
  - cnt = 0, duty_r = 255, raw_q = 0, THETA_OUT = 0
  - state = IDLE, PWM_H = 0, PWM_L = 0, PERIOD_STRB = 0
  - Reset mid-operation behaves the same way, with no glitch on PWM_H/PWM_L.
- All outputs are registered.
- Carrier counter:
  - 9-bit cnt counts 0..509 while EN = 1, then wraps to 0.
  - While EN = 0, cnt is held at 0.
- Duty conversion:
  - duty = sign-extended SINE_IN + 255, computed 10 bits wide, range 0..510.
  - SINE_IN = 9'h100 (-256) clamps to duty 0.
- Period update, on the edge where cnt == 509 and EN = 1:
  - duty_r <= duty
  - THETA_OUT <= THETA_OUT + PHASE_STEP
  - PERIOD_STRB <= 1 for exactly one cycle, coinciding with cnt == 0.
  - The new duty applies from cnt == 0 onward.
  - The LUT output therefore stays stable for the whole period; no mid-period duty change is possible.
- Raw PWM:
  - raw_q <= EN && (cnt < duty_r).
  - duty_r 0 gives raw_q always 0; duty_r 510 gives raw_q always 1.
- Dead-time FSM (Moore, outputs decoded from the state register):
  - IDLE: both outputs low. EN = 1 -> DT.
  - DT: both outputs low; dt_cnt is loaded with DEAD-1 on entry.
    - Any change of raw_q while in DT reloads dt_cnt.
    - When dt_cnt == 0: go to HI if raw_q = 1, else LO.
  - HI: PWM_H = 1. raw_q falls -> DT.
  - LO: PWM_L = 1. raw_q rises -> DT.
  - EN = 0 from any state -> IDLE on the next edge; both outputs are low in the following cycle.
- Invariants and consequences:
  - PWM_H and PWM_L are never high together.
  - Every transition between them passes through at least DEAD low-low cycles.
  - Pulses shorter than DEAD are swallowed.
  - Steady state: PWM_H high for duty_r - DEAD cycles per period; PWM_L high for 510 - duty_r - DEAD cycles. Both numbers are valid when they are > 0.
- Latency: cnt -> raw_q is 1 clock; raw_q -> state is 1 clock, plus DEAD when a DT interval is entered.

Decomposition:
- Shared package sine_pwm_pkg holds:
  - constants CARRIER_MAX = 509 and DUTY_OFFSET = 255
  - the state enum {IDLE, DT, HI, LO}
  - sample width 9 and phase width 8
- One natural sub-module: dead_time_gen. It contains the FSM plus dt_cnt, takes raw_q and EN, and drives PWM_H and PWM_L.

Test Plan:
- Reset check: assert RST_N low mid-period while PWM_H = 1 -> in the same cycle PWM_H = PWM_L = 0 and THETA_OUT = 0; after release with EN = 1, the first drive is preceded by 4 DT cycles.
- Half duty: SINE_IN = 0, EN = 1, DEAD = 4 -> each 510-cycle period has PWM_H = 251 cycles, PWM_L = 251 cycles and 8 low-low cycles; PERIOD_STRB fires every 510 cycles.
- Full scale: SINE_IN = +255 -> PWM_H high continuously after the initial DT. SINE_IN = 9'h100 -> duty clamps to 0 and PWM_L is high continuously.
- Short-pulse suppression: SINE_IN = -253 (duty 2), DEAD = 4 -> PWM_H never asserts and PWM_L never asserts outside DT.
- Phase sweep: PHASE_STEP = 1 for 257 periods -> THETA_OUT increments once per PERIOD_STRB and wraps 255 -> 0. With PHASE_STEP = 64, THETA_OUT follows 0, 64, 128, 192, 0.
- Enable drop: EN deasserted at cnt = 100 -> both outputs are low on the next cycle, cnt holds at 0 and THETA_OUT freezes; on re-enable the period restarts at cnt = 0 with DT first.
